ifetch_unit: RTL
================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset; state clears immediately when reset=0.
REQ-004 ireq  output  ibus_req_t  instruction bus request; only valid and addr driven, all other fields 0.
REQ-005 iresp  input  ibus_resp_t  instruction bus response; data_ok and data used, addr_ok ignored.
REQ-006 redirect_valid  input  1  core requests a fetch-stream restart this cycle.
REQ-007 redirect_pc  input  64  restart address; bits [1:0] forced to 0 internally.
REQ-008 out_valid  output  1  buffered instruction available to the core.
REQ-009 out_ready  input  1  core accepts the buffered instruction this cycle.
REQ-010 out_pc  output  64  address of the buffered instruction.
REQ-011 out_instr  output  32  buffered instruction word.

Function
REQ-012 The FSM SHALL have three states: REQ (request outstanding), HOLD (instruction buffered), DISCARD (stale request outstanding, response to be dropped).
REQ-013 ireq.valid SHALL be 1 in REQ and DISCARD, 0 in HOLD; ireq.addr SHALL equal the current fetch pc and stay stable until data_ok.
REQ-014 In REQ with data_ok=1 and redirect_valid=0: latch iresp.data into out_instr, latch pc into out_pc, set pc to pc+4, move to HOLD.
REQ-015 In REQ with data_ok=1 and redirect_valid=1: drop the data, set pc to redirect_pc, stay in REQ; the new request appears the next cycle.
REQ-016 In REQ with data_ok=0 and redirect_valid=1: store redirect_pc in a pending register, keep ireq.addr at the old pc, move to DISCARD.
REQ-017 In DISCARD on data_ok=1: drop the data, set pc to the pending value, move to REQ.
REQ-018 In DISCARD, a further redirect_valid SHALL overwrite the pending value (last wins); if data_ok is also 1, the new redirect_pc SHALL be used.
REQ-019 out_valid SHALL be 1 only in HOLD; out_pc and out_instr SHALL be stable while out_valid=1.
REQ-020 In HOLD with out_ready=1 and redirect_valid=0: handshake completes, move to REQ, fetch continues at pc (already +4).
REQ-021 In HOLD with redirect_valid=1: redirect wins over out_ready, no handshake is counted, set pc to redirect_pc, move to REQ, out_valid drops next cycle.
REQ-022 Latency: data_ok in cycle N gives out_valid=1 in cycle N+1; a handshake in cycle M gives ireq.valid=1 in cycle M+1.
REQ-023 The pc increment SHALL be 64-bit modulo: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
REQ-024 data_ok while in HOLD (protocol violation) SHALL be ignored.

Reset
REQ-025 While reset=0: state=REQ, pc=RESET_PC, pending=0, out_valid=0, out_pc=0, out_instr=0, ireq.valid=0, ireq.addr=RESET_PC.
REQ-026 On reset release, ireq.valid SHALL be 1 with addr=RESET_PC from the first cycle.
REQ-027 Reset asserted mid-request SHALL abandon the request; a data_ok arriving during reset SHALL be ignored.

Verification
REQ-028 Sequential fetch: release reset, data_ok with data 32'h00000013 after 2 cycles, out_ready=1 -> out_pc=8000_0000 and out_instr=00000013 on the next cycle; next ireq.addr=8000_0004.
REQ-029 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid held at 1, out_pc and out_instr unchanged, ireq.valid=0 throughout.
REQ-030 Redirect with request outstanding: redirect_pc=8000_0100 while addr=8000_0008 and no data_ok -> addr stays 8000_0008 until data_ok, the data is dropped (out_valid stays 0), then addr=8000_0100.
REQ-031 Redirect in HOLD with out_ready=1 in the same cycle, redirect_pc=8000_0203 -> no handshake, next ireq.addr=8000_0200, out_valid=0.
REQ-032 Double redirect in DISCARD: 8000_0100 then 8000_0200, data_ok later -> next ireq.addr=8000_0200.
REQ-033 Wrap and reset: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one fetch -> next addr=0; reset=0 mid-request -> out_valid=0, addr=RESET_PC, and the late data_ok is ignored.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding fetch request, a single-entry
// instruction buffer toward the core, and redirect handling that drops
// responses belonging to an abandoned fetch stream.

package ifetch_pkg;

  // Instruction bus request. The fetch unit only ever reads, so only
  // valid and addr carry information; the remaining fields are tied to 0.
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } ibus_req_t;

  // Instruction bus response. addr_ok is carried by the bus but not needed
  // here: the request is held until data_ok, which doubles as the accept.
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

endpackage

module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  // S_REQ     : request for pc outstanding on the bus
  // S_HOLD    : instruction buffered, waiting for the core to take it
  // S_DISCARD : request for a stale pc outstanding, its data will be dropped
  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] pc;
  logic [63:0] pc_nxt;
  logic [63:0] pend_pc;
  logic [63:0] pend_pc_nxt;
  logic        load_out;
  logic [63:0] redir_pc;
  logic [63:0] pc_inc;
  logic        unused_bits;

  // Instructions are word aligned; the low two redirect bits are discarded.
  assign redir_pc = {redirect_pc[63:2], 2'b00};

  // Sequential pc step, wraps modulo 2^64.
  assign pc_inc = pc + 64'd4;

  // Bits that are part of the interface but carry nothing this unit uses.
  assign unused_bits = ^{iresp.addr_ok, redirect_pc[1:0]};

  // State, fetch pc and pending redirect target registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      pend_pc <= 64'd0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pend_pc <= pend_pc_nxt;
    end
  end

  // Next-state logic: decides pc updates, redirect capture and buffer load.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pend_pc_nxt = pend_pc;
    load_out    = 1'b0;
    case (state)
      S_REQ: begin
        if (iresp.data_ok) begin
          if (redirect_valid) begin
            // Response belongs to the old stream; restart right away.
            pc_nxt = redir_pc;
          end else begin
            load_out  = 1'b1;
            pc_nxt    = pc_inc;
            state_nxt = S_HOLD;
          end
        end else if (redirect_valid) begin
          // The bus request cannot be withdrawn: keep the address stable,
          // remember where to go, and drop whatever comes back.
          pend_pc_nxt = redir_pc;
          state_nxt   = S_DISCARD;
        end
      end
      S_DISCARD: begin
        // A newer redirect replaces the pending target (last one wins).
        if (redirect_valid) begin
          pend_pc_nxt = redir_pc;
        end
        if (iresp.data_ok) begin
          pc_nxt    = redirect_valid ? redir_pc : pend_pc;
          state_nxt = S_REQ;
        end
      end
      S_HOLD: begin
        // Redirect beats the handshake: the buffered instruction is stale.
        // Any data_ok seen here is a bus protocol violation and is ignored.
        if (redirect_valid) begin
          pc_nxt    = redir_pc;
          state_nxt = S_REQ;
        end else if (out_ready) begin
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  // Instruction buffer toward the core; only written on a kept response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_pc    <= 64'd0;
      out_instr <= 32'd0;
    end else if (load_out) begin
      out_pc    <= pc;
      out_instr <= iresp.data;
    end
  end

  // Bus request and core-side valid decode. The request is gated by reset
  // so nothing is presented while reset is held, yet it is live on the very
  // first cycle after release.
  always_comb begin
    ireq       = '0;
    ireq.valid = reset && (state != S_HOLD);
    ireq.addr  = pc;
    out_valid  = (state == S_HOLD);
  end

endmodule
